// File: rtl/fetch_pc_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pc_pkg
// Shared types for the fetch PC unit.
//   state_e : fetch FSM state (BOOT / RUN / HOLD)
//   src_e   : source of a redirect (NONE / ID / EX); EX outranks ID
// The ST_* constants hold the state encodings in the legacy form; the enum is
// built on them so both views agree.
// ---------------------------------------------------------------------------
package fetch_pc_pkg;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef enum logic [1:0] {
        BOOT = ST_BOOT,
        RUN  = ST_RUN,
        HOLD = ST_HOLD
    } state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ID   = 2'd1,
        EX   = 2'd2
    } src_e;

endpackage

// File: rtl/fetch_pc_unit_ras.sv
// ---------------------------------------------------------------------------
// fetch_ras
// Circular return-address stack. A push when full overwrites the oldest entry;
// a pop when empty is ignored and the stack stays empty.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset (clears pointers)
//   push, pop       : stack operations (never both in one cycle)
//   push_data [AW]  : value pushed
//   top [AW]        : current top entry (valid only when empty=0)
//   empty           : no entries held
// Parameters: RAS_DEPTH (power of two, >=2), AW (entry width).
// ---------------------------------------------------------------------------
module fetch_ras
    import fetch_pc_pkg::*;
#(
    parameter int RAS_DEPTH = 4,
    parameter int AW        = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic          empty
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem [RAS_DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_inc;
    logic [CW-1:0] count;

    assign ptr_inc = ptr + PW'(1);
    assign top     = mem[ptr];
    assign empty   = (count == '0);

    // Pointer and occupancy; the pointer wraps naturally, so a push when full
    // simply lands on the oldest slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr_inc;
            if (count != CW'(RAS_DEPTH))
                count <= count + CW'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
        end
    end

    // Entry storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[ptr_inc] <= push_data;
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
// Generates the word fetch address. Redirect priority: EX (taken branch or
// register jump) > ID (direct jump, or return when the stack is built) >
// sequential increment. Redirects take effect on the next edge; redirects
// arriving while stalled are held in a one-entry pending slot.
// Optional feature: define FETCH_PC_RAS_EN to build a return-address stack
// (jmp_call pushes, ret_valid pops and redirects). Without it ret_valid and
// jmp_call are ignored.
// Ports:
//   clk, reset                     : clock, asynchronous active-low reset
//   stall                          : hold the PC
//   br_valid, br_taken, br_pc, br_off : EX branch, target br_pc+1+br_off (words)
//   jr_valid, jr_reg               : EX register jump, byte address
//   jmp_valid, jmp_call, jmp_target: ID direct jump / call, word address
//   ret_valid                      : ID return hint
//   pc, pc_valid                   : fetch word address and its qualifier
//   flush_if, flush_id             : registered one-cycle kill strobes
// ---------------------------------------------------------------------------
module fetch_pc_unit
    import fetch_pc_pkg::*;
#(
    parameter int            AW        = 32,
    parameter logic [AW-1:0] RESET_PC  = '0,
    parameter int            RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          br_valid,
    input  logic          br_taken,
    input  logic [AW-1:0] br_pc,
    input  logic [AW-1:0] br_off,
    input  logic          jr_valid,
    input  logic [AW-1:0] jr_reg,
    input  logic          jmp_valid,
    input  logic          jmp_call,
    input  logic [AW-1:0] jmp_target,
    input  logic          ret_valid,
    output logic [AW-1:0] pc,
    output logic          pc_valid,
    output logic          flush_if,
    output logic          flush_id
);

    state_e        state;
    src_e          pend_src;
    logic [AW-1:0] pend_tgt;

    logic                 active;
    logic                 br_hit;
    logic                 ex_hit;
    logic signed [AW-1:0] br_off_s;
    logic signed [AW-1:0] br_tgt_s;
    logic [AW-1:0]        ex_tgt;
    logic                 id_hit;
    logic [AW-1:0]        id_tgt;
    src_e                 new_src;
    logic [AW-1:0]        new_tgt;
    logic                 pend_load;

    assign active   = (state != BOOT);
    assign br_hit   = br_valid && br_taken;
    assign ex_hit   = br_hit || jr_valid;
    assign br_off_s = $signed(br_off);
    assign br_tgt_s = $signed(br_pc) + $signed(AW'(1)) + br_off_s;
    assign ex_tgt   = br_hit ? $unsigned(br_tgt_s) : {2'b00, jr_reg[AW-1:2]};

`ifdef FETCH_PC_RAS_EN
    logic [AW-1:0] id_pc;
    logic [AW-1:0] ras_top;
    logic          ras_empty;
    logic          ras_push;
    logic          ras_pop;
    logic          unused_ok;

    assign unused_ok = &{1'b0, jr_reg[1:0]};

    // Stack operations are only committed for an ID redirect that survives
    // arbitration; an EX redirect in the same cycle cancels them.
    always_comb begin
        id_hit   = jmp_valid;
        id_tgt   = jmp_target;
        ras_push = active && !ex_hit && jmp_valid && jmp_call;
        ras_pop  = active && !ex_hit && !jmp_valid && ret_valid && !ras_empty;
        if (!jmp_valid && ret_valid && !ras_empty) begin
            id_hit = 1'b1;
            id_tgt = ras_top;
        end
    end

    // Address of the word now in decode: the word fetched on the last advance.
    always_ff @(posedge clk) begin
        if (active && !stall)
            id_pc <= pc;
    end

    fetch_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .AW        (AW)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (id_pc + AW'(1)),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_ok;

    assign unused_ok = &{1'b0, jr_reg[1:0], jmp_call, ret_valid};

    always_comb begin
        id_hit = jmp_valid;
        id_tgt = jmp_target;
    end
`endif

    always_comb begin
        new_src = NONE;
        new_tgt = ex_tgt;
        if (ex_hit) begin
            new_src = EX;
            new_tgt = ex_tgt;
        end else if (id_hit) begin
            new_src = ID;
            new_tgt = id_tgt;
        end
    end

    // While stalled, an EX redirect always replaces the pending slot; an ID
    // redirect only fills it if it does not already hold an EX redirect.
    assign pend_load = active && stall &&
                       ((new_src == EX) || ((new_src == ID) && (pend_src != EX)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            pc_valid <= 1'b0;
            flush_if <= 1'b0;
            flush_id <= 1'b0;
            pend_src <= NONE;
        end else begin
            flush_if <= 1'b0;
            flush_id <= 1'b0;
            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                default: begin
                    if (stall) begin
                        state <= HOLD;
                        if (pend_load)
                            pend_src <= new_src;
                    end else begin
                        state    <= RUN;
                        pend_src <= NONE;
                        // A fresh redirect outranks whatever was pending.
                        if (new_src != NONE) begin
                            pc       <= new_tgt;
                            flush_if <= 1'b1;
                            flush_id <= (new_src == EX);
                        end else if (pend_src != NONE) begin
                            pc       <= pend_tgt;
                            flush_if <= 1'b1;
                            flush_id <= (pend_src == EX);
                        end else begin
                            pc <= pc + AW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Pending target is payload only; pend_src says whether it is meaningful.
    always_ff @(posedge clk) begin
        if (pend_load)
            pend_tgt <= new_tgt;
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, br_valid, br_taken, jr_valid, jmp_valid, jmp_call, ret_valid;
    logic [31:0] br_pc, br_off, jr_reg, jmp_target;
    logic [31:0] pc;
    logic        pc_valid, flush_if, flush_id;

    logic [7:0]  w_pc;
    logic        w_pv, w_fi, w_fd;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_pc_unit #(.AW(32), .RESET_PC(32'h10), .RAS_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .br_valid(br_valid), .br_taken(br_taken), .br_pc(br_pc), .br_off(br_off),
        .jr_valid(jr_valid), .jr_reg(jr_reg),
        .jmp_valid(jmp_valid), .jmp_call(jmp_call), .jmp_target(jmp_target),
        .ret_valid(ret_valid),
        .pc(pc), .pc_valid(pc_valid), .flush_if(flush_if), .flush_id(flush_id)
    );

    fetch_pc_unit #(.AW(8), .RESET_PC(8'hFE), .RAS_DEPTH(4)) dut_w (
        .clk(clk), .reset(reset), .stall(1'b0),
        .br_valid(1'b0), .br_taken(1'b0), .br_pc(8'h00), .br_off(8'h00),
        .jr_valid(1'b0), .jr_reg(8'h00),
        .jmp_valid(1'b0), .jmp_call(1'b0), .jmp_target(8'h00),
        .ret_valid(1'b0),
        .pc(w_pc), .pc_valid(w_pv), .flush_if(w_fi), .flush_id(w_fd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 1'b0; br_valid = 1'b0; br_taken = 1'b0; jr_valid = 1'b0;
        jmp_valid = 1'b0; jmp_call = 1'b0; ret_valid = 1'b0;
        br_pc = '0; br_off = '0; jr_reg = '0; jmp_target = '0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e_pc,
                           input logic e_fi, input logic e_fd);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".flush_if"}, 32'(flush_if), 32'(e_fi));
        chk({tag, ".flush_id"}, 32'(flush_id), 32'(e_fd));
    endtask

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk_out("reset", 32'h10, 1'b0, 1'b0);
        chk("reset.pc_valid", 32'(pc_valid), 32'h0);

        // Release: one BOOT cycle, then 0x10, 0x11, 0x12
        reset = 1'b1;
        chk("boot.pc_valid", 32'(pc_valid), 32'h0);
        tick();
        chk("run0.pc_valid", 32'(pc_valid), 32'h1);
        chk_out("run0", 32'h10, 1'b0, 1'b0);
        chk("wrap0", 32'(w_pc), 32'hFE);
        tick();
        chk_out("run1", 32'h11, 1'b0, 1'b0);
        chk("wrap1", 32'(w_pc), 32'hFF);
        tick();
        chk_out("run2", 32'h12, 1'b0, 1'b0);
        chk("wrap2", 32'(w_pc), 32'h00);

        // Taken branch beats same-cycle jump: 0x20 + 1 - 3 = 0x1E
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h20; br_off = 32'hFFFF_FFFD;
        jmp_valid = 1'b1; jmp_target = 32'h80;
        tick(); idle();
        chk_out("br_vs_jmp", 32'h1E, 1'b1, 1'b1);
        tick();
        chk_out("after_br", 32'h1F, 1'b0, 1'b0);

        // Not-taken branch is no redirect
        br_valid = 1'b1; br_taken = 1'b0; br_pc = 32'h40; br_off = 32'h4;
        tick(); idle();
        chk_out("br_nt", 32'h20, 1'b0, 1'b0);

        // Register jump: 0x103 >> 2 = 0x40
        jr_valid = 1'b1; jr_reg = 32'h103;
        tick(); idle();
        chk_out("jr", 32'h40, 1'b1, 1'b1);

        // ID jump flushes IF only
        jmp_valid = 1'b1; jmp_target = 32'h200;
        tick(); idle();
        chk_out("jmp", 32'h200, 1'b1, 1'b0);
        tick();
        chk_out("after_jmp", 32'h201, 1'b0, 1'b0);

        // Stall 3 cycles: jump in cycle 1, branch (0x5F+1+0=0x60) in cycle 2
        stall = 1'b1; jmp_valid = 1'b1; jmp_target = 32'h50;
        tick();
        chk_out("stall1", 32'h201, 1'b0, 1'b0);
        jmp_valid = 1'b0; br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h5F; br_off = 32'h0;
        tick();
        chk_out("stall2", 32'h201, 1'b0, 1'b0);
        br_valid = 1'b0; br_taken = 1'b0;
        tick();
        chk_out("stall3", 32'h201, 1'b0, 1'b0);
        stall = 1'b0;
        tick();
        chk_out("release_ex", 32'h60, 1'b1, 1'b1);
        tick();
        chk_out("after_release", 32'h61, 1'b0, 1'b0);

        // Pending EX (0x70) is not overwritten by a later ID jump
        stall = 1'b1; br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h6F; br_off = 32'h0;
        tick();
        br_valid = 1'b0; br_taken = 1'b0; jmp_valid = 1'b1; jmp_target = 32'h90;
        tick(); idle();
        chk("hold_keep.pc", pc, 32'h61);
        tick();
        chk_out("pend_ex_kept", 32'h70, 1'b1, 1'b1);

        // Pending ID jump loses to a jr arriving with the stall release
        stall = 1'b1; jmp_valid = 1'b1; jmp_target = 32'h300;
        tick(); idle();
        jr_valid = 1'b1; jr_reg = 32'h1000;
        tick(); idle();
        chk_out("new_beats_pend", 32'h400, 1'b1, 1'b1);

        // Stall with nothing pending resumes increment
        stall = 1'b1;
        tick(); idle();
        chk_out("plain_hold", 32'h400, 1'b0, 1'b0);
        tick();
        chk_out("plain_resume", 32'h401, 1'b0, 1'b0);

        // Reset in mid-HOLD with a pending jump discards it
        stall = 1'b1; jmp_valid = 1'b1; jmp_target = 32'h500;
        tick(); idle();
        #2 reset = 1'b0;
        #1;
        chk_out("async_reset", 32'h10, 1'b0, 1'b0);
        chk("async_reset.pc_valid", 32'(pc_valid), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        chk("reboot.pc_valid", 32'(pc_valid), 32'h0);
        tick();
        chk_out("reboot0", 32'h10, 1'b0, 1'b0);
        tick();
        chk_out("reboot1", 32'h11, 1'b0, 1'b0);

`ifdef FETCH_PC_RAS_EN
        // Land on pc=1, then call from decode PCs 1..5 (pushes 2..6)
        jr_valid = 1'b1; jr_reg = 32'h4;
        tick(); idle();
        chk("ras_entry.pc", pc, 32'h1);
        tick();
        for (int k = 1; k <= 5; k++) begin
            jmp_valid = 1'b1; jmp_call = 1'b1; jmp_target = 32'(k + 2);
            tick(); idle();
        end
        chk("ras_calls.pc", pc, 32'h7);
        ret_valid = 1'b1;
        tick();
        chk_out("ret1", 32'h6, 1'b1, 1'b0);
        tick();
        chk_out("ret2", 32'h5, 1'b1, 1'b0);
        tick();
        chk_out("ret3", 32'h4, 1'b1, 1'b0);
        tick();
        chk_out("ret4", 32'h3, 1'b1, 1'b0);
        tick(); idle();
        chk_out("ret5_empty", 32'h4, 1'b0, 1'b0);
`else
        // Without the stack, a return hint does nothing
        ret_valid = 1'b1; jmp_call = 1'b1;
        tick(); idle();
        chk_out("ret_ignored", 32'h12, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
